// File: rtl/eof_pkg.sv
// Shared types and defaults for the EOF frame path.
// The receiver uses the same gap constant as the transmitter.
package eof_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam int FRAME_LEN_DEF  = 64;
  localparam int GAP_CYCLES_DEF = 43;

endpackage

// File: rtl/eof_frame_tx_if.sv
// Word stream bundle: upstream valid/ready input side
// plus the framed output stream with SOF/EOF markers.
interface eof_frame_tx_if
  import eof_pkg::*;
#(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              SOF;
  logic              EOF;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  SOF,
    input  EOF
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    output SOF,
    output EOF
  );

endinterface

// File: rtl/eof_gap_timer.sv
// Loadable up-counter with terminal-count flag,
// used to time the inter-frame gap.
module eof_gap_timer
  import eof_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/eof_frame_tx.sv
// Fixed-length frame transmitter with registered SOF/EOF
// and an enforced minimum idle gap after every EOF.
module eof_frame_tx
  import eof_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  eof_frame_tx_if.slave bus,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int IDX_W =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_LEN - 1);
  localparam logic [7:0] GAP_LAST =
    8'(GAP_CYCLES - 1);

  state_t            state;
  logic [IDX_W-1:0]  word_idx;
  logic              start_pend;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              sof_q;
  logic              eof_q;

  logic ready;
  logic xfer;
  logic last_word;
  logic gap_tc;

  assign ready     = (state == SEND);
  assign xfer      = bus.in_valid && ready;
  assign last_word = (word_idx == LAST_IDX);
  assign busy      = (state != IDLE);

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.SOF       = sof_q;
  assign bus.EOF       = eof_q;

  // Cleared on the final transfer so GAP starts at zero.
  eof_gap_timer #(
    .W(8)
  ) u_gap (
    .clock(clock),
    .reset(reset),
    .load (xfer && last_word),
    .en   (state == GAP),
    .last (GAP_LAST),
    .tc   (gap_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      word_idx   <= '0;
      start_pend <= 1'b0;
      frame_cnt  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start || start_pend) begin
            state      <= SEND;
            start_pend <= 1'b0;
          end
        end
        SEND: begin
          if (start) begin
            start_pend <= 1'b1;
          end
          if (xfer) begin
            data_q  <= bus.in_data;
            valid_q <= 1'b1;
            sof_q   <= (word_idx == '0);
            eof_q   <= last_word;
            if (last_word) begin
              word_idx  <= '0;
              frame_cnt <= frame_cnt + 8'd1;
              state     <= GAP;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        GAP: begin
          if (start) begin
            start_pend <= 1'b1;
          end
          if (gap_tc) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eof_frame_tx.sv
// Directed bench for eof_frame_tx with FRAME_LEN=4 and
// GAP_CYCLES=43; expectations are hand-derived cycle numbers.
module tb_eof_frame_tx;
  import eof_pkg::*;

  localparam int DW = 16;
  localparam int FL = 4;
  localparam int GC = 43;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic [7:0] frame_cnt;

  eof_frame_tx_if #(.DATA_W(DW)) bus ();

  eof_frame_tx #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .GAP_CYCLES(GC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  string tname = "";

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s cyc=%0d got=%0h exp=%0h",
               tname, tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int last_eof;
    int nsof;
    int k;
    logic [15:0] exp_d;

    // Basic frame and reset values
    tname = "reset";
    do_reset();
    @(negedge clock);
    check("in_ready", bus.in_ready, 0);
    check("out_valid", bus.out_valid, 0);
    check("SOF", bus.SOF, 0);
    check("EOF", bus.EOF, 0);
    check("out_data", bus.out_data, 0);
    check("busy", busy, 0);
    check("frame_cnt", frame_cnt, 0);

    tname = "basic";
    for (int t = 0; t < 50; t++) begin
      drive_edge();
      cyc = t;
      start        = (t == 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h100 + t);
      @(negedge clock);
      check("out_valid", bus.out_valid, t >= 2 && t <= 5);
      check("SOF", bus.SOF, t == 2);
      check("EOF", bus.EOF, t == 5);
      if (t >= 2 && t <= 5)
        check("out_data", bus.out_data, 16'h100 + t - 1);
      check("frame_cnt", frame_cnt, (t >= 5) ? 1 : 0);
      check("busy", busy, t >= 1 && t <= 47);
      check("in_ready", bus.in_ready, t >= 1 && t <= 4);
    end

    // Bubbles: valid on odd cycles only
    tname = "bubble";
    do_reset();
    exp_d = '0;
    for (int t = 0; t < 54; t++) begin
      drive_edge();
      cyc = t;
      start        = (t == 0);
      bus.in_valid = (t >= 1) && (t % 2 == 1);
      bus.in_data  = 16'(16'h200 + t);
      @(negedge clock);
      if (t >= 2 && t <= 8 && t % 2 == 0)
        exp_d = 16'(16'h200 + t - 1);
      check("out_valid", bus.out_valid,
            t >= 2 && t <= 8 && t % 2 == 0);
      check("out_data", bus.out_data, exp_d);
      check("SOF", bus.SOF, t == 2);
      check("EOF", bus.EOF, t == 8);
      check("frame_cnt", frame_cnt, (t >= 8) ? 1 : 0);
      check("busy", busy, t >= 1 && t <= 50);
      check("in_ready", bus.in_ready, t >= 1 && t <= 7);
    end

    // Pending start: pulses in SEND and GAP give one frame
    tname = "pend";
    do_reset();
    for (int t = 0; t < 101; t++) begin
      drive_edge();
      cyc = t;
      start        = (t == 0) || (t == 3) || (t == 20);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h300 + t);
      @(negedge clock);
      check("out_valid", bus.out_valid,
            (t >= 2 && t <= 5) || (t >= 50 && t <= 53));
      if ((t >= 2 && t <= 5) || (t >= 50 && t <= 53))
        check("out_data", bus.out_data, 16'h300 + t - 1);
      check("SOF", bus.SOF, t == 2 || t == 50);
      check("EOF", bus.EOF, t == 5 || t == 53);
      check("frame_cnt", frame_cnt,
            (t >= 53) ? 2 : (t >= 5) ? 1 : 0);
      check("busy", busy,
            (t >= 1 && t <= 47) || (t >= 49 && t <= 95));
      check("in_ready", bus.in_ready,
            (t >= 1 && t <= 4) || (t >= 49 && t <= 52));
    end

    // Gap enforcement with start held high
    tname = "gap";
    do_reset();
    last_eof = -1;
    nsof     = 0;
    for (int t = 0; t < 200; t++) begin
      drive_edge();
      cyc = t;
      start        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h400 + t);
      @(negedge clock);
      if (last_eof >= 0 && t < last_eof + GC)
        check("in_ready_gap", bus.in_ready, 0);
      if (bus.SOF === 1'b1) begin
        nsof++;
        if (last_eof >= 0)
          check("spacing", t - last_eof, GC + 2);
      end
      if (bus.EOF === 1'b1)
        last_eof = t;
    end
    check("sof_count", nsof, 5);

    // Reset mid-frame, then reset together with start
    tname = "midrst";
    do_reset();
    for (int t = 0; t < 65; t++) begin
      drive_edge();
      cyc = t;
      reset        = (t == 3) || (t == 61);
      start        = (t == 0) || (t == 61);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h500 + t);
      @(negedge clock);
      if (t == 2 || t == 3) begin
        check("out_valid", bus.out_valid, 1);
        check("out_data", bus.out_data, 16'h500 + t - 1);
      end
      if (t >= 4) begin
        check("out_valid", bus.out_valid, 0);
        check("EOF", bus.EOF, 0);
        check("busy", busy, 0);
        check("in_ready", bus.in_ready, 0);
        check("frame_cnt", frame_cnt, 0);
      end
      if (t == 4)
        check("out_data", bus.out_data, 0);
    end

    // Counter wrap over 256 frames
    tname = "wrap";
    do_reset();
    k = 0;
    for (int t = 0; t < 13000 && k < 256; t++) begin
      drive_edge();
      cyc = t;
      start        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(t);
      @(negedge clock);
      if (bus.EOF === 1'b1) begin
        k++;
        check("frame_cnt", frame_cnt, k % 256);
        if (k == 255)
          check("cnt_255", frame_cnt, 255);
        if (k == 256)
          check("cnt_0", frame_cnt, 0);
      end
    end
    check("frames_done", k, 256);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
